// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract sequencer: runs one 8-bit add/sub slice over NBYTES bytes,
// LSB first, with a registered carry between bytes and a start/busy/done handshake.
module addsub_seq_ctrl #(
   parameter int NBYTES = 4,
   localparam int W = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf
);

   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_next;

   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          op_reg;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-9:0]  shadow;

   logic [7:0]    a_byte;
   logic [7:0]    b_byte;
   logic [8:0]    sum9;
   logic [W-1:0]  shadow_ext;
   logic          accept;
   logic          last;

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == RUN) && (idx == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (idx == LAST) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Subtract is A + ~B + 1: B is inverted per byte and the carry chain starts at op.
   always_comb begin
      a_byte     = a_reg[{idx, 3'b000} +: 8];
      b_byte     = b_reg[{idx, 3'b000} +: 8] ^ {8{op_reg}};
      sum9       = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
      shadow_ext = {sum9[7:0], shadow};
   end

   // Completed bytes shift in from the top, so after NBYTES-1 steps byte 0 sits at
   // the bottom and the final slice output supplies the top byte directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= 1'b0;
         idx    <= '0;
         carry  <= 1'b0;
         shadow <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         a_reg  <= a;
         b_reg  <= b;
         op_reg <= op;
         idx    <= '0;
         carry  <= op;
         shadow <= '0;
      end else if (state == RUN) begin
         shadow <= shadow_ext[W-1:8];
         carry  <= sum9[8];
         idx    <= idx + 1'b1;
         if (last) begin
            result <= {sum9[7:0], shadow};
            cout   <= sum9[8];
            ovf    <= (a_byte[7] == b_byte[7]) && (sum9[7] != a_byte[7]);
         end
      end
   end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed vector table, handshake/reset corner sequences and a randomized sweep
// against a W-bit reference model for addsub_seq_ctrl with NBYTES=4.
module tb_addsub_seq_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   addsub_seq_ctrl #(.NBYTES(NB)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Launch one operation, then scramble the operand inputs to show they are not re-sampled.
   task automatic applyStimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = ~o;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(output int nbusy, output logic got);
      nbusy = 0;
      got   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) nbusy++;
      end
   endtask

   initial begin
      int           nb;
      logic         got;
      logic         seen;
      logic         o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] er;
      logic         ec;
      logic         eo;
      longint       sr;

      vecs[0]  = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset result", result, 0);
      checkOutput("reset cout", cout, 0);
      checkOutput("reset ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(nb, got);
         checkOutput($sformatf("vec%0d done seen", i), got, 1);
         checkOutput($sformatf("vec%0d busy cycles", i), nb, NB);
         checkOutput($sformatf("vec%0d result", i), result, vecs[i].res);
         checkOutput($sformatf("vec%0d cout", i), cout, vecs[i].cout);
         checkOutput($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
         @(negedge clk);
         checkOutput($sformatf("vec%0d done one cycle", i), done, 0);
         checkOutput($sformatf("vec%0d result hold", i), result, vecs[i].res);
      end

      // Asynchronous reset while idle with a nonzero result held.
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("async rst busy", busy, 0);
      checkOutput("async rst done", done, 0);
      checkOutput("async rst result", result, 0);
      checkOutput("async rst cout", cout, 0);
      checkOutput("async rst ovf", ovf, 0);
      #2;
      rst = 1'b0;

      // start during RUN is ignored and not queued.
      applyStimulus(1'b0, 32'h000000FF, 32'h00000001);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'h11111111;
      b     = 32'h22222222;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb, got);
      checkOutput("run-start done seen", got, 1);
      checkOutput("run-start remaining busy", nb, 2);
      checkOutput("run-start result", result, 32'h00000100);
      checkOutput("run-start cout", cout, 0);
      checkOutput("run-start ovf", ovf, 0);
      @(negedge clk);
      checkOutput("run-start not queued busy", busy, 0);
      checkOutput("run-start not queued done", done, 0);

      // start during the done cycle is accepted back-to-back.
      applyStimulus(1'b0, 32'h7FFFFFFF, 32'h00000001);
      wait_done(nb, got);
      checkOutput("b2b first done seen", got, 1);
      checkOutput("b2b first result", result, 32'h80000000);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'h80000000;
      b     = 32'h00000001;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 32'hDEADBEEF;
      checkOutput("b2b busy next cycle", busy, 1);
      checkOutput("b2b result held in run", result, 32'h80000000);
      checkOutput("b2b ovf held in run", ovf, 1);
      wait_done(nb, got);
      checkOutput("b2b second done seen", got, 1);
      checkOutput("b2b second busy cycles", nb, NB);
      checkOutput("b2b second result", result, 32'h7FFFFFFF);
      checkOutput("b2b second cout", cout, 1);
      checkOutput("b2b second ovf", ovf, 1);

      // Reset during the second RUN cycle cancels the operation.
      applyStimulus(1'b0, 32'h7FFFFFFF, 32'h00000001);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort result", result, 0);
      checkOutput("abort cout", cout, 0);
      checkOutput("abort ovf", ovf, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      checkOutput("abort no done or busy", seen, 0);
      checkOutput("abort result stays zero", result, 0);
      applyStimulus(1'b0, 32'h00000003, 32'h00000004);
      wait_done(nb, got);
      checkOutput("fresh add done seen", got, 1);
      checkOutput("fresh add result", result, 32'h00000007);
      checkOutput("fresh add cout", cout, 0);
      checkOutput("fresh add ovf", ovf, 0);

      // Randomized sweep: 1000 adds and 1000 subtracts against an exact-arithmetic model.
      for (int i = 0; i < 2000; i++) begin
         o = (i >= 1000);
         x = $urandom;
         y = $urandom;
         if (i % 9 == 0) y = x;
         if (i % 13 == 0) y = ~x;
         if (!o) begin
            er = x + y;
            ec = ({1'b0, x} + {1'b0, y}) > 33'h0FFFFFFFF;
            sr = longint'($signed(x)) + longint'($signed(y));
         end else begin
            er = x - y;
            ec = (x >= y);
            sr = longint'($signed(x)) - longint'($signed(y));
         end
         eo = (sr != longint'($signed(er)));
         applyStimulus(o, x, y);
         wait_done(nb, got);
         checkOutput($sformatf("rand%0d done seen", i), got, 1);
         checkOutput($sformatf("rand%0d result op=%0d a=%08h b=%08h", i, o, x, y), result, er);
         checkOutput($sformatf("rand%0d cout", i), cout, ec);
         checkOutput($sformatf("rand%0d ovf", i), ovf, eo);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Sequencing controller that performs wide (NBYTES×8-bit) add/subtract by time-multiplexing a single internal 8-bit add/sub slice, one byte per clock, LSB first, with a registered carry chain.
- It is the control layer that lets the 8-bit add/sub datapath serve wider operands in the arithmetic block.
- It exposes a start/busy/done handshake to the requester.

Parameters:
- NBYTES, 4, number of 8-bit slices per operand (≥2); operand width W = 8*NBYTES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on rising clk.
- op  input  1  0 = add (A+B), 1 = subtract (A−B); sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while bytes are being processed.
- done  output  1  one-cycle pulse: result/cout/ovf valid.
- result  output  W  A+B or A−B, modulo 2^W.
- cout  output  1  raw carry out of MSB (subtract: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal operand, shadow, byte-index and carry registers are cleared.
  - A cancelled operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: latch a, b, op; idx←0; carry←op; shadow←0; go to RUN.
- RUN:
  - busy=1, done=0.
  - Each cycle computes slice byte idx: {c,s} = A[idx] + (B[idx] XOR {8{op}}) + carry.
  - s goes to shadow byte idx; carry←c; idx←idx+1.
  - On the edge that processes idx=NBYTES−1, all of the following happen and the state goes to DONE:
    - result←complete shadow, with the top byte being the current s.
    - cout←c.
    - ovf←(A_msb == Bmod_msb) && (s[7] != A_msb), where Bmod = B XOR op.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next state is IDLE, unless start=1, in which case the new operands are latched and the state goes directly to RUN (back-to-back).
- Latency: start sampled at edge E0 → done high during the cycle after edge E0+NBYTES. busy is high for exactly NBYTES cycles.
- result, cout, ovf change only on the final RUN edge or on reset. They hold their value through IDLE and through the next operation's RUN cycles.
- start while in RUN: ignored. It is not queued and latched operands are unaffected.
- a, b, op are sampled only on the accepting edge; changes during RUN have no effect.
- Wrap-around: result is modulo 2^W. Overflow is reported only via cout and ovf.
- Subtract: implemented as A + ~B + 1 (initial carry = 1), so cout=0 indicates a borrow (A<B unsigned).

Test Plan (NBYTES=4):
1. Reset:
   - Stimulus: assert rst mid-simulation with start=0.
   - Required: busy=0, done=0, result=0, cout=0, ovf=0 immediately (asynchronous, before next clk edge).
2. Add with inter-byte carry:
   - Stimulus: op=0, a=0x000000FF, b=0x00000001.
   - Required: busy high for 4 cycles; done at E0+4 with result=0x00000100, cout=0, ovf=0.
   - Add wrap: a=0xFFFFFFFF, b=0x00000001 → result=0x00000000, cout=1, ovf=0.
3. Signed overflow:
   - Add: op=0, a=0x7FFFFFFF, b=1 → result=0x80000000, cout=0, ovf=1.
   - Subtract: op=1, a=0x80000000, b=1 → result=0x7FFFFFFF, cout=1, ovf=1.
4. Borrow:
   - Stimulus: op=1, a=0x00000000, b=0x00000001.
   - Required: result=0xFFFFFFFF, cout=0, ovf=0.
   - Also: op=1, a=0x12345678, b=0x12345678 → result=0, cout=1, ovf=0.
5. Handshake edge cases:
   - Stimulus: start re-asserted with new operands during RUN.
   - Required: ignored; the first result completes unchanged.
   - Stimulus: start asserted during the done cycle.
   - Required: accepted; busy=1 on the next cycle; the second done arrives 4 cycles later with the correct second result.
6. Reset mid-operation:
   - Stimulus: assert rst during the 2nd RUN cycle, release it, then issue a fresh add 3+4.
   - Required: no done pulse for the aborted operation; outputs are 0; the fresh add returns result=7.
   - Then run a randomized sweep of ≥1000 operand pairs per op against a W-bit reference model.
